// File: rtl/gradient_read_arbiter_if.sv
// Requester/BRAM-side bus of gradient_read_arbiter: burst read requests, the shared
// BRAM address, raw BRAM data and tagged responses.
interface gradient_read_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 12,
   parameter int BIT_DEPTH  = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            req_ready;
   logic [ADDR_WIDTH-1:0]         bram_addr;
   logic signed [BIT_DEPTH-1:0]   x_grad_in;
   logic signed [BIT_DEPTH-1:0]   y_grad_in;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic signed [BIT_DEPTH-1:0]   rsp_x_grad;
   logic signed [BIT_DEPTH-1:0]   rsp_y_grad;
   logic                          busy;

   modport slave (
      input  req_valid, req_last, req_addr, x_grad_in, y_grad_in,
      output req_ready, bram_addr, rsp_valid, rsp_x_grad, rsp_y_grad, busy
   );
   modport master (
      output req_valid, req_last, req_addr, x_grad_in, y_grad_in,
      input  req_ready, bram_addr, rsp_valid, rsp_x_grad, rsp_y_grad, busy
   );
endinterface

// File: rtl/gradient_read_arbiter.sv
// Burst-locked round-robin arbiter sharing one gradient BRAM read port; responses are tagged
// in-order. Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead.
module gradient_read_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int ADDR_WIDTH   = 12,
   parameter int BIT_DEPTH    = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst_in,
   gradient_read_arbiter_if.slave  bus
);
   localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int STAGES = READ_LATENCY;

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t                          state_q, state_d;
   logic [IW-1:0]                   owner_q, owner_d;
   logic [IW-1:0]                   ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
   logic [STAGES:0]                 vld_pipe_q, vld_pipe_d;
   logic [STAGES:0][IW-1:0]         idx_pipe_q, idx_pipe_d;
   logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
   logic signed [BIT_DEPTH-1:0]     rsp_x_q, rsp_x_d;
   logic signed [BIT_DEPTH-1:0]     rsp_y_q, rsp_y_d;

   logic          accept;
   logic          found;
   logic [IW-1:0] win;
   logic [IW-1:0] owner_nxt;
   int            scan;

   // In the fixed-priority build ptr never leaves 0, so the same scan yields lowest-index-wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      scan  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = int'(ptr_q) + k;
         if (scan >= NUM_REQ) scan = scan - NUM_REQ;
         if (!found && bus.req_valid[scan]) begin
            found = 1'b1;
            win   = IW'(scan);
         end
      end
   end

   assign accept    = (state_q == GRANTED) && bus.req_valid[owner_q];
   assign owner_nxt = (int'(owner_q) == NUM_REQ-1) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      addr_d      = addr_q;
      vld_pipe_d  = {vld_pipe_q[STAGES-1:0], accept};
      idx_pipe_d  = {idx_pipe_q[STAGES-1:0], owner_q};
      rsp_valid_d = '0;
      rsp_x_d     = rsp_x_q;
      rsp_y_d     = rsp_y_q;
      case (state_q)
         IDLE: if (found) begin
            owner_d = win;
            state_d = GRANTED;
         end
         GRANTED: if (accept) begin
            addr_d = bus.req_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
            if (bus.req_last[owner_q]) begin
               state_d = IDLE;
`ifdef ARB_FIXED_PRIORITY_EN
               ptr_d = '0;
`else
               ptr_d = owner_nxt;
`endif
            end
         end
      endcase
      // Pipe tail lines up with BRAM data for the beat issued READ_LATENCY+1 cycles earlier.
      if (vld_pipe_q[STAGES]) begin
         rsp_valid_d = NUM_REQ'(1) << idx_pipe_q[STAGES];
         rsp_x_d     = bus.x_grad_in;
         rsp_y_d     = bus.y_grad_in;
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         ptr_q       <= '0;
         addr_q      <= '0;
         vld_pipe_q  <= '0;
         idx_pipe_q  <= '0;
         rsp_valid_q <= '0;
         rsp_x_q     <= '0;
         rsp_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
         addr_q      <= addr_d;
         vld_pipe_q  <= vld_pipe_d;
         idx_pipe_q  <= idx_pipe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_x_q     <= rsp_x_d;
         rsp_y_q     <= rsp_y_d;
      end
   end

   assign bus.req_ready  = (state_q == GRANTED) ? (NUM_REQ'(1) << owner_q) : '0;
   assign bus.bram_addr  = addr_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_x_grad = rsp_x_q;
   assign bus.rsp_y_grad = rsp_y_q;
   assign bus.busy       = (state_q == GRANTED) | (|vld_pipe_q);
endmodule

// File: tb/tb_gradient_read_arbiter.sv
// Randomized bench for gradient_read_arbiter against a transaction-level arbitration/scoreboard model.
module tb_gradient_read_arbiter;
   localparam int N  = 3;
   localparam int AW = 12;
   localparam int BD = 8;
   localparam int RL = 2;

   logic clk = 1'b0;
   logic rst_in = 1'b0;
   always #5 clk = ~clk;

   gradient_read_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BIT_DEPTH(BD)) bus ();

   gradient_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BIT_DEPTH(BD), .READ_LATENCY(RL)) dut (
      .clk(clk), .rst_in(rst_in), .bus(bus)
   );

   function automatic logic signed [BD-1:0] fx(input logic [AW-1:0] a);
      return BD'(a - AW'(10));
   endfunction
   function automatic logic signed [BD-1:0] fy(input logic [AW-1:0] a);
      return BD'(a * 3 + 1);
   endfunction

   // BRAM model: data for an address appears READ_LATENCY cycles after it is presented.
   logic [AW-1:0] ash [RL];
   initial for (int k = 0; k < RL; k++) ash[k] = '0;
   always @(posedge clk) begin
      ash[0] <= bus.bram_addr;
      for (int k = 1; k < RL; k++) ash[k] <= ash[k-1];
   end
   assign bus.x_grad_in = fx(ash[RL-1]);
   assign bus.y_grad_in = fy(ash[RL-1]);

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Stimulus state
   logic [N-1:0]  drv_valid, drv_last;
   logic [AW-1:0] drv_addr [N];
   int            rem [N];

   task automatic drive();
      bus.req_valid = drv_valid;
      bus.req_last  = drv_last;
      for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = drv_addr[i];
   endtask

   task automatic drive_idle();
      drv_valid = '0;
      drv_last  = '0;
      for (int i = 0; i < N; i++) begin drv_addr[i] = '0; rem[i] = 0; end
      drive();
   endtask

   // Reference model: grant flag/owner/pointer plus expected-response scoreboard
   typedef struct { int due; int idx; logic [AW-1:0] a; } ent_t;
   ent_t          sb [$];
   int            grants [$];
   bit            m_gr;
   int            m_own, m_ptr;
   logic [AW-1:0] m_addr;
   logic [N-1:0]  acc;

   task automatic model_reset();
      m_gr = 0; m_own = 0; m_ptr = 0; m_addr = '0;
      sb.delete();
   endtask

   task automatic step();
      logic [N-1:0] exp_rdy;
      bit bexp;
      ent_t e;
      @(negedge clk);
      exp_rdy = m_gr ? N'(1 << m_own) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("bram_addr", 32'(bus.bram_addr), 32'(m_addr));
      bexp = m_gr;
      foreach (sb[k]) if (sb[k].due > cyc) bexp = 1;
      chk("busy", 32'(bus.busy), 32'(bexp));
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << e.idx));
         chk("rsp_x", 32'(bus.rsp_x_grad), 32'(fx(e.a)));
         chk("rsp_y", 32'(bus.rsp_y_grad), 32'(fy(e.a)));
      end else begin
         chk("rsp_idle", 32'(bus.rsp_valid), 32'(0));
      end
      acc = '0;
      if (m_gr) begin
         if (drv_valid[m_own]) begin
            acc[m_own] = 1'b1;
            sb.push_back('{cyc + 2 + RL, m_own, drv_addr[m_own]});
            m_addr = drv_addr[m_own];
            if (drv_last[m_own]) begin
               m_gr = 0;
`ifdef ARB_FIXED_PRIORITY_EN
               m_ptr = 0;
`else
               m_ptr = (m_own + 1) % N;
`endif
            end
         end
      end else if (|drv_valid) begin
         for (int k = N-1; k >= 0; k--)
            if (drv_valid[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
         m_gr = 1;
         grants.push_back(m_own);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic rand_drive();
      for (int i = 0; i < N; i++) begin
         if (acc[i]) rem[i]--;
         if (rem[i] == 0 && $urandom_range(3) == 0) rem[i] = 1 + $urandom_range(3);
         drv_valid[i] = (rem[i] > 0) && ($urandom_range(3) != 0);
         drv_last[i]  = (rem[i] == 1);
         drv_addr[i]  = AW'($urandom);
      end
      drive();
   endtask

   initial begin
      drive_idle();
      model_reset();
      #3;
      chk("rst_ready", 32'(bus.req_ready), 32'(0));
      chk("rst_addr", 32'(bus.bram_addr), 32'(0));
      chk("rst_rsp", 32'(bus.rsp_valid), 32'(0));
      chk("rst_x", 32'(bus.rsp_x_grad), 32'(0));
      chk("rst_y", 32'(bus.rsp_y_grad), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      @(posedge clk); @(posedge clk); #1;
      rst_in = 1'b1;

      // Idle after reset
      repeat (20) step();

      // All requesters issue single-beat bursts back to back
      grants.delete();
      drv_valid = '1; drv_last = '1;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < N; i++) drv_addr[i] = AW'($urandom);
         drive();
         step();
      end
      chk("grant_count", 32'(grants.size()), 32'(6));
      foreach (grants[k]) begin
`ifdef ARB_FIXED_PRIORITY_EN
         chk("grant_order", 32'(grants[k]), 32'(0));
`else
         chk("grant_order", 32'(grants[k]), 32'(k % N));
`endif
      end
      drive_idle();
      repeat (8) step();

      // R0 burst 5,6,7
      begin
         int beats = 0;
         for (int c = 0; c < 20 && beats < 3; c++) begin
            drv_valid = 3'b001;
            drv_addr[0] = AW'(5 + beats);
            drv_last = (beats == 2) ? 3'b001 : 3'b000;
            drive();
            step();
            if (acc[0]) beats++;
         end
         chk("burst_beats", 32'(beats), 32'(3));
      end
      drive_idle();
      repeat (8) step();
      chk("burst_drained", 32'(bus.busy), 32'(0));

      // Random traffic
      acc = '0;
      repeat (3000) begin
         rand_drive();
         step();
      end

      // Async reset with reads in flight
      begin
         int w = 0;
         while (sb.size() < 2 && w < 200) begin
            rand_drive();
            step();
            w++;
         end
         chk("inflight_found", 32'(sb.size() >= 2), 32'(1));
      end
      #2 rst_in = 1'b0;
      #1;
      chk("arst_rsp", 32'(bus.rsp_valid), 32'(0));
      chk("arst_busy", 32'(bus.busy), 32'(0));
      chk("arst_ready", 32'(bus.req_ready), 32'(0));
      drive_idle();
      model_reset();
      @(posedge clk); #1;
      cyc++;
      rst_in = 1'b1;
      repeat (10) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
